reg_file_status: RTL and testbench



---
 rtl/reg_file_status_pkg.sv | 14 +
 rtl/reg_file_status_status_reg.sv | 37 +++
 rtl/reg_file_status.sv | 80 ++++++++
 tb/tb_reg_file_status.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/reg_file_status_pkg.sv
// rtl/reg_file_status_pkg.sv - shared widths and write-back select encoding for reg_file_status
package reg_file_status_pkg;

    localparam int DW_DEF       = 8;
    localparam int AW_DEF       = 3;
    localparam int ZERO_REG_DEF = 1;

    // Write-back source select, shared with the instruction decoder
    typedef enum logic {
        WB_ALU = 1'b0,
        WB_MEM = 1'b1
    } wb_sel_e;

endpackage

// File: rtl/reg_file_status_status_reg.sv
// rtl/reg_file_status_status_reg.sv - FLAG/OVERFLOW status bits, forwarding under REGFILE_BYPASS_EN
module status_reg (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_flag_d,
    input  logic i_flag_we,
    input  logic i_ovf_d,
    input  logic i_ovf_we,
    output logic o_flag,
    output logic o_ovf
);

    logic r_flag;
    logic r_ovf;

    // Each status bit has its own enable so the ALU can update them independently
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_flag <= 1'b0;
            r_ovf  <= 1'b0;
        end else begin
            if (i_flag_we) r_flag <= i_flag_d;
            if (i_ovf_we)  r_ovf  <= i_ovf_d;
        end
    end

    // Forward the incoming bit when bypass is built in, otherwise expose stored state
    always_comb begin
        o_flag = r_flag;
        o_ovf  = r_ovf;
`ifdef REGFILE_BYPASS_EN
        if (!i_reset && i_flag_we) o_flag = i_flag_d;
        if (!i_reset && i_ovf_we)  o_ovf  = i_ovf_d;
`endif
    end

endmodule

// File: rtl/reg_file_status.sv
// rtl/reg_file_status.sv - ALU-side register file with status bits; REGFILE_BYPASS_EN enables write-before-read forwarding
module reg_file_status
    import reg_file_status_pkg::*;
#(
    parameter int DW       = DW_DEF,
    parameter int AW       = AW_DEF,
    parameter int ZERO_REG = ZERO_REG_DEF
) (
    input  logic          CLK,
    input  logic          RESET,
    input  logic [AW-1:0] RADDR_A,
    input  logic [AW-1:0] RADDR_B,
    input  logic [AW-1:0] WADDR,
    input  logic          WRITE_EN,
    input  logic          WB_SEL,
    input  logic [DW-1:0] ALU_IN,
    input  logic [DW-1:0] MEM_IN,
    input  logic          FLAG_D,
    input  logic          FLAG_WE,
    input  logic          OVF_D,
    input  logic          OVF_WE,
    output logic [DW-1:0] DATA_A,
    output logic [DW-1:0] DATA_B,
    output logic          FLAG,
    output logic          OVERFLOW
);

    localparam int NREGS = 2 ** AW;

    logic [DW-1:0] r_regs [NREGS];
    logic [DW-1:0] w_wdata;
    logic          w_wr_ok;
    wb_sel_e       w_wb_sel;

    assign w_wb_sel = wb_sel_e'(WB_SEL);
    assign w_wdata  = (w_wb_sel == WB_MEM) ? MEM_IN : ALU_IN;
    // A write to a hardwired r0 is dropped here so it can never be stored or forwarded
    assign w_wr_ok  = WRITE_EN && !RESET && !((ZERO_REG != 0) && (WADDR == '0));

    // Register array: cleared on reset, otherwise one write per cycle
    always_ff @(posedge CLK) begin
        if (RESET) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_wr_ok) begin
            r_regs[WADDR] <= w_wdata;
        end
    end

    // Read port A: stored value, optional forwarding, r0 forced to zero last
    always_comb begin
        DATA_A = r_regs[RADDR_A];
`ifdef REGFILE_BYPASS_EN
        if (w_wr_ok && (RADDR_A == WADDR)) DATA_A = w_wdata;
`endif
        if ((ZERO_REG != 0) && (RADDR_A == '0)) DATA_A = '0;
    end

    // Read port B: same structure as port A
    always_comb begin
        DATA_B = r_regs[RADDR_B];
`ifdef REGFILE_BYPASS_EN
        if (w_wr_ok && (RADDR_B == WADDR)) DATA_B = w_wdata;
`endif
        if ((ZERO_REG != 0) && (RADDR_B == '0)) DATA_B = '0;
    end

    status_reg u_status (
        .i_clk     (CLK),
        .i_reset   (RESET),
        .i_flag_d  (FLAG_D),
        .i_flag_we (FLAG_WE),
        .i_ovf_d   (OVF_D),
        .i_ovf_we  (OVF_WE),
        .o_flag    (FLAG),
        .o_ovf     (OVERFLOW)
    );

endmodule

// File: tb/tb_reg_file_status.sv
// tb/tb_reg_file_status.sv - directed self-checking bench for reg_file_status
module tb_reg_file_status;

    logic       CLK = 1'b0;
    logic       RESET;
    logic [2:0] RADDR_A, RADDR_B, WADDR;
    logic       WRITE_EN, WB_SEL;
    logic [7:0] ALU_IN, MEM_IN;
    logic       FLAG_D, FLAG_WE, OVF_D, OVF_WE;
    logic [7:0] DATA_A, DATA_B, DATA_A0, DATA_B0;
    logic       FLAG, OVERFLOW, FLAG0, OVERFLOW0;
    logic [7:0] alu_sum;

    int checks = 0;
    int errors = 0;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    always #5 CLK = ~CLK;

    reg_file_status #(.DW(8), .AW(3), .ZERO_REG(1)) dut (
        .CLK(CLK), .RESET(RESET), .RADDR_A(RADDR_A), .RADDR_B(RADDR_B),
        .WADDR(WADDR), .WRITE_EN(WRITE_EN), .WB_SEL(WB_SEL),
        .ALU_IN(ALU_IN), .MEM_IN(MEM_IN), .FLAG_D(FLAG_D), .FLAG_WE(FLAG_WE),
        .OVF_D(OVF_D), .OVF_WE(OVF_WE), .DATA_A(DATA_A), .DATA_B(DATA_B),
        .FLAG(FLAG), .OVERFLOW(OVERFLOW)
    );

    reg_file_status #(.DW(8), .AW(3), .ZERO_REG(0)) dut0 (
        .CLK(CLK), .RESET(RESET), .RADDR_A(RADDR_A), .RADDR_B(RADDR_B),
        .WADDR(WADDR), .WRITE_EN(WRITE_EN), .WB_SEL(WB_SEL),
        .ALU_IN(ALU_IN), .MEM_IN(MEM_IN), .FLAG_D(FLAG_D), .FLAG_WE(FLAG_WE),
        .OVF_D(OVF_D), .OVF_WE(OVF_WE), .DATA_A(DATA_A0), .DATA_B(DATA_B0),
        .FLAG(FLAG0), .OVERFLOW(OVERFLOW0)
    );

    task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        RESET = 1'b1; RADDR_A = 3'd0; RADDR_B = 3'd0; WADDR = 3'd0;
        WRITE_EN = 1'b0; WB_SEL = 1'b0; ALU_IN = 8'h00; MEM_IN = 8'h00;
        FLAG_D = 1'b0; FLAG_WE = 1'b0; OVF_D = 1'b0; OVF_WE = 1'b0;
        tick();
        tick();
        RESET = 1'b0;
        RADDR_A = 3'd1; RADDR_B = 3'd7;
        #1;
        chk8("rst_a", DATA_A, 8'h00);
        chk8("rst_b", DATA_B, 8'h00);
        chk1("rst_flag", FLAG, 1'b0);
        chk1("rst_ovf", OVERFLOW, 1'b0);

        // preload r1=A5, FLAG=1
        WRITE_EN = 1'b1; WADDR = 3'd1; ALU_IN = 8'hA5; WB_SEL = 1'b0;
        FLAG_D = 1'b1; FLAG_WE = 1'b1;
        tick();
        WRITE_EN = 1'b0; FLAG_WE = 1'b0; FLAG_D = 1'b0;
        #1;
        chk8("preload_r1", DATA_A, 8'hA5);
        chk1("preload_flag", FLAG, 1'b1);

        // reset with a pending write to r2
        RESET = 1'b1; WRITE_EN = 1'b1; WADDR = 3'd2; ALU_IN = 8'h33;
        tick();
        RESET = 1'b0; WRITE_EN = 1'b0;
        RADDR_A = 3'd1; RADDR_B = 3'd2;
        #1;
        chk8("rst2_r1", DATA_A, 8'h00);
        chk8("rst2_r2", DATA_B, 8'h00);
        chk1("rst2_flag", FLAG, 1'b0);
        chk1("rst2_ovf", OVERFLOW, 1'b0);

        // write r3 from ALU_IN, then r4 from MEM_IN
        WRITE_EN = 1'b1; WADDR = 3'd3; WB_SEL = 1'b0; ALU_IN = 8'h3C; MEM_IN = 8'h5A;
        tick();
        WADDR = 3'd4; WB_SEL = 1'b1; ALU_IN = 8'h77; MEM_IN = 8'hF0;
        RADDR_A = 3'd3; RADDR_B = 3'd4;
        #1;
        chk8("r3_during_r4_wr", DATA_A, 8'h3C);
        chk8("r4_during_wr", DATA_B, BYP ? 8'hF0 : 8'h00);
        tick();
        WRITE_EN = 1'b0;
        #1;
        chk8("r3_after", DATA_A, 8'h3C);
        chk8("r4_mem", DATA_B, 8'hF0);

        // zero register
        WRITE_EN = 1'b1; WADDR = 3'd0; WB_SEL = 1'b0; ALU_IN = 8'hFF;
        RADDR_A = 3'd0; RADDR_B = 3'd0;
        #1;
        chk8("r0_wr_cycle", DATA_A, 8'h00);
        chk8("r0_ord_wr_cycle", DATA_A0, BYP ? 8'hFF : 8'h00);
        tick();
        WRITE_EN = 1'b0;
        #1;
        chk8("r0_next", DATA_A, 8'h00);
        chk8("r0_ord_next", DATA_A0, 8'hFF);

        // read during write
        WRITE_EN = 1'b1; WADDR = 3'd5; ALU_IN = 8'h11;
        tick();
        ALU_IN = 8'h22; RADDR_A = 3'd5; RADDR_B = 3'd5;
        #1;
        chk8("rdw_a", DATA_A, BYP ? 8'h22 : 8'h11);
        chk8("rdw_b", DATA_B, BYP ? 8'h22 : 8'h11);
        tick();
        WRITE_EN = 1'b0;
        #1;
        chk8("rdw_a_next", DATA_A, 8'h22);
        chk8("rdw_b_next", DATA_B, 8'h22);

        // status enables
        FLAG_D = 1'b1; FLAG_WE = 1'b0;
        #1;
        chk1("flag_no_we_now", FLAG, 1'b0);
        tick();
        chk1("flag_no_we", FLAG, 1'b0);
        FLAG_D = 1'b1; FLAG_WE = 1'b1; OVF_D = 1'b1; OVF_WE = 1'b1;
        #1;
        chk1("flag_fwd", FLAG, BYP);
        chk1("ovf_fwd", OVERFLOW, BYP);
        tick();
        FLAG_WE = 1'b0; OVF_WE = 1'b0;
        #1;
        chk1("flag_set", FLAG, 1'b1);
        chk1("ovf_set", OVERFLOW, 1'b1);
        FLAG_D = 1'b0; FLAG_WE = 1'b1; OVF_D = 1'b0; OVF_WE = 1'b0;
        tick();
        FLAG_WE = 1'b0;
        #1;
        chk1("flag_clr", FLAG, 1'b0);
        chk1("ovf_hold", OVERFLOW, 1'b1);
        OVF_D = 1'b0; OVF_WE = 1'b1;
        tick();
        OVF_WE = 1'b0;
        #1;
        chk1("ovf_clr", OVERFLOW, 1'b0);

        // ALU add r1=FF + r2=01 into r6 with overflow set
        WRITE_EN = 1'b1; WB_SEL = 1'b0; WADDR = 3'd1; ALU_IN = 8'hFF;
        tick();
        WADDR = 3'd2; ALU_IN = 8'h01;
        tick();
        WRITE_EN = 1'b0; RADDR_A = 3'd1; RADDR_B = 3'd2;
        #1;
        chk8("alu_opa", DATA_A, 8'hFF);
        chk8("alu_opb", DATA_B, 8'h01);
        WRITE_EN = 1'b1; WADDR = 3'd6; ALU_IN = 8'h00; OVF_D = 1'b1; OVF_WE = 1'b1;
        tick();
        WRITE_EN = 1'b0; OVF_WE = 1'b0; OVF_D = 1'b0;
        RADDR_A = 3'd6; RADDR_B = 3'd2;
        #1;
        chk8("alu_r6", DATA_A, 8'h00);
        chk1("alu_ovf", OVERFLOW, 1'b1);
        // next add uses OVERFLOW as carry-in: 00 + 01 + 1 = 02
        alu_sum = DATA_A + DATA_B + {7'b0, OVERFLOW};
        chk8("alu_carry_in_sum", alu_sum, 8'h02);
        WRITE_EN = 1'b1; WADDR = 3'd7; ALU_IN = alu_sum;
        FLAG_D = 1'b1; FLAG_WE = 1'b1; OVF_D = 1'b0; OVF_WE = 1'b1;
        tick();
        WRITE_EN = 1'b0; FLAG_WE = 1'b0; OVF_WE = 1'b0;
        RADDR_A = 3'd7; RADDR_B = 3'd0;
        #1;
        chk8("alu_r7", DATA_A, 8'h02);
        chk1("combo_flag", FLAG, 1'b1);
        chk1("combo_ovf", OVERFLOW, 1'b0);
        chk8("r0_ord_kept", DATA_B0, 8'hFF);
        chk8("r0_zero_kept", DATA_B, 8'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
